// File: rtl/wishbone_master_xactor.sv
// Pipelined Wishbone B4 master: client requests become STB beats inside one CYC,
// and ACK/ERR terminations return in issue order through a response FIFO.
module wishbone_master_xactor #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [DATA_WIDTH/8-1:0] req_sel,
  input  logic [ADDR_WIDTH-1:0]   req_adr,
  input  logic [DATA_WIDTH-1:0]   req_dat,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_dat,
  output logic                    rsp_we,
  output logic                    rsp_err,
  output logic                    CYC_O,
  output logic                    STB_O,
  output logic                    WE_O,
  output logic [ADDR_WIDTH-1:0]   ADR_O,
  output logic [DATA_WIDTH/8-1:0] SEL_O,
  output logic [DATA_WIDTH-1:0]   DAT_O,
  input  logic                    STALL_I,
  input  logic                    ACK_I,
  input  logic                    ERR_I,
  input  logic [DATA_WIDTH-1:0]   DAT_I,
  output logic                    protocol_err
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [CW:0] MAX_L = (CW+1)'(MAX_OUTSTANDING);

  logic                  stb_q, stb_d, we_q, we_d, cyc_q, cyc_d, perr_q, perr_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [CW-1:0]         out_q, out_d, cnt_q, cnt_d;
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [EW-1:0]         mem_q [MAX_OUTSTANDING];
  logic [EW-1:0]         push_data, head;
  logic                  beat, term, elig, credit_ok, dir_ok, accept, push, pop;
  logic [CW:0]           load;

  always_comb begin
    beat      = stb_q && !STALL_I;
    term      = ACK_I || ERR_I;
    // A termination is only legal for a beat already issued or issuing now
    elig      = term && ((out_q != '0) || beat);
    // Reserve a FIFO slot for every beat in flight: ACK cannot be stalled
    load      = {1'b0, out_q} + {1'b0, cnt_q} + (CW+1)'(stb_q);
    credit_ok = load < MAX_L;
    dir_ok    = !cyc_q || (req_we == we_q);
    req_ready = (!stb_q || !STALL_I) && credit_ok && dir_ok;
    accept    = req_valid && req_ready;
    push      = elig;
    pop       = (cnt_q != '0) && rsp_ready;
    push_data = {(we_q ? {DATA_WIDTH{1'b0}} : DAT_I), we_q, ERR_I};

    stb_d = stb_q;
    we_d  = we_q;
    adr_d = adr_q;
    sel_d = sel_q;
    dat_d = dat_q;
    if (accept) begin
      stb_d = 1'b1;
      we_d  = req_we;
      adr_d = req_adr;
      sel_d = req_sel;
      dat_d = req_dat;
    end else if (beat) begin
      stb_d = 1'b0;
    end

    out_d = out_q;
    if (beat && !elig)      out_d = out_q + CW'(1);
    else if (!beat && elig) out_d = out_q - CW'(1);

    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);

    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
    cyc_d  = stb_d || (out_d != '0);
    perr_d = perr_q || (term && !elig);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stb_q  <= 1'b0;
      we_q   <= 1'b0;
      adr_q  <= '0;
      sel_q  <= '0;
      dat_q  <= '0;
      cyc_q  <= 1'b0;
      out_q  <= '0;
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      perr_q <= 1'b0;
    end else begin
      stb_q  <= stb_d;
      we_q   <= we_d;
      adr_q  <= adr_d;
      sel_q  <= sel_d;
      dat_q  <= dat_d;
      cyc_q  <= cyc_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      perr_q <= perr_d;
    end
  end

  // Storage needs no reset: validity is tracked by the pointers and count
  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

  assign head         = mem_q[rptr_q];
  assign rsp_valid    = (cnt_q != '0);
  assign rsp_dat      = head[EW-1:2];
  assign rsp_we       = head[1];
  assign rsp_err      = head[0];
  assign CYC_O        = cyc_q;
  assign STB_O        = stb_q;
  assign WE_O         = we_q;
  assign ADR_O        = adr_q;
  assign SEL_O        = sel_q;
  assign DAT_O        = dat_q;
  assign protocol_err = perr_q;
endmodule

// File: tb/tb_wishbone_master_xactor.sv
// Directed bench for wishbone_master_xactor: single read, stall hold, credit limit,
// direction switch, error/unsolicited terminations and mid-burst async reset.
module tb_wishbone_master_xactor;
  logic        CLK = 1'b0, RST = 1'b1;
  logic        req_valid = 0, req_ready, req_we = 0;
  logic [3:0]  req_sel = 0;
  logic [31:0] req_adr = 0, req_dat = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_we, rsp_err;
  logic [31:0] rsp_dat;
  logic        CYC_O, STB_O, WE_O;
  logic [31:0] ADR_O, DAT_O;
  logic [3:0]  SEL_O;
  logic        STALL_I = 0, ACK_I = 0, ERR_I = 0;
  logic [31:0] DAT_I = 0;
  logic        protocol_err;
  int checks = 0, failures = 0;

  wishbone_master_xactor dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_sel(req_sel), .req_adr(req_adr), .req_dat(req_dat), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_we(rsp_we), .rsp_err(rsp_err),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .SEL_O(SEL_O), .DAT_O(DAT_O),
    .STALL_I(STALL_I), .ACK_I(ACK_I), .ERR_I(ERR_I), .DAT_I(DAT_I), .protocol_err(protocol_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] d, input logic we, input logic err);
    chk({tag, "_valid"}, rsp_valid, 1'b1);
    chk({tag, "_dat"}, rsp_dat, d);
    chk({tag, "_we"}, rsp_we, we);
    chk({tag, "_err"}, rsp_err, err);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // Streams n reads; the slave ACKs each beat one cycle after issue, ERR on beat err_idx
  task automatic burst(input int n, input int err_idx, input logic [31:0] base,
                       output int acc, output int beats);
    int  acks;
    logic ack_next, hs, iss;
    acc = 0; beats = 0; acks = 0; ack_next = 0;
    for (int c = 0; c < 40; c++) begin
      ACK_I     = ack_next;
      ERR_I     = ack_next && (acks == err_idx);
      DAT_I     = base + 32'(acks);
      req_valid = (acc < n);
      req_we    = 1'b0;
      req_sel   = 4'hF;
      req_adr   = 32'h200 + 32'(acc * 4);
      #1;
      hs  = req_valid && req_ready;
      iss = STB_O && !STALL_I;
      @(posedge CLK); #1;
      if (ack_next) acks++;
      if (hs) acc++;
      if (iss) beats++;
      ack_next = iss;
    end
    ACK_I = 0; ERR_I = 0; req_valid = 0;
  endtask

  initial begin
    int acc, beats;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_cyc", CYC_O, 1'b0);
    chk("rst_stb", STB_O, 1'b0);
    chk("rst_adr", ADR_O, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_perr", protocol_err, 1'b0);
    RST = 1'b0;
    tick();

    // Single read
    req_valid = 1; req_we = 0; req_adr = 32'h100; req_sel = 4'hF;
    #1 chk("rd_ready", req_ready, 1'b1);
    tick();
    req_valid = 0;
    chk("rd_stb", STB_O, 1'b1);
    chk("rd_cyc", CYC_O, 1'b1);
    chk("rd_adr", ADR_O, 32'h100);
    chk("rd_we", WE_O, 1'b0);
    tick();
    chk("rd_stb_drop", STB_O, 1'b0);
    chk("rd_cyc_hold", CYC_O, 1'b1);
    ACK_I = 1; DAT_I = 32'hDEADBEEF;
    tick();
    ACK_I = 0;
    chk("rd_cyc_fall", CYC_O, 1'b0);
    pop_chk("rd_rsp", 32'hDEADBEEF, 1'b0, 1'b0);
    chk("rd_empty", rsp_valid, 1'b0);

    // Stall hold
    req_valid = 1; req_we = 1; req_adr = 32'h4; req_sel = 4'hF; req_dat = 32'h12345678;
    STALL_I = 1;
    tick();
    req_adr = 32'h8; req_dat = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_stb", STB_O, 1'b1);
      chk("st_adr", ADR_O, 32'h4);
      chk("st_dat", DAT_O, 32'h12345678);
      chk("st_sel", SEL_O, 4'hF);
      chk("st_we", WE_O, 1'b1);
      chk("st_ready", req_ready, 1'b0);
      tick();
    end
    req_valid = 0; STALL_I = 0;
    tick();
    chk("st_stb_drop", STB_O, 1'b0);
    chk("st_sel_keep", SEL_O, 4'hF);
    chk("st_outstanding", dut.out_q, 4'd1);
    ACK_I = 1;
    tick();
    ACK_I = 0;
    pop_chk("st_rsp", 32'h0, 1'b1, 1'b0);

    // Credit limit: nothing popped, 10 reads requested
    burst(10, -1, 32'hA0000000, acc, beats);
    chk("cr_accepted", acc, 8);
    chk("cr_beats", beats, 8);
    req_valid = 1; req_we = 0;
    #1 chk("cr_ready_closed", req_ready, 1'b0);
    req_valid = 0;
    pop_chk("cr_rsp0", 32'hA0000000, 1'b0, 1'b0);
    req_valid = 1;
    #1 chk("cr_ready_reopen", req_ready, 1'b1);
    req_valid = 0;
    for (int k = 1; k < 8; k++) pop_chk("cr_rsp", 32'hA0000000 + 32'(k), 1'b0, 1'b0);
    chk("cr_empty", rsp_valid, 1'b0);

    // Direction switch
    req_valid = 1; req_we = 1; req_adr = 32'h10; req_sel = 4'h3; req_dat = 32'hCAFE;
    #1 chk("dir_wr_ready", req_ready, 1'b1);
    tick();
    req_we = 0; req_adr = 32'h20;
    #1 chk("dir_rd_blocked", req_ready, 1'b0);
    chk("dir_we1", WE_O, 1'b1);
    tick();
    ACK_I = 1;
    #1 chk("dir_rd_blocked2", req_ready, 1'b0);
    chk("dir_we2", WE_O, 1'b1);
    chk("dir_cyc", CYC_O, 1'b1);
    tick();
    ACK_I = 0;
    #1 chk("dir_cyc_low", CYC_O, 1'b0);
    chk("dir_rd_ready", req_ready, 1'b1);
    tick();
    req_valid = 0;
    chk("dir_rd_stb", STB_O, 1'b1);
    chk("dir_rd_we", WE_O, 1'b0);
    chk("dir_rd_adr", ADR_O, 32'h20);
    tick();
    ACK_I = 1; DAT_I = 32'h55;
    tick();
    ACK_I = 0;
    pop_chk("dir_rsp_wr", 32'h0, 1'b1, 1'b0);
    pop_chk("dir_rsp_rd", 32'h55, 1'b0, 1'b0);

    // Error on second of three reads (ACK and ERR both high on it)
    burst(3, 1, 32'hB0000000, acc, beats);
    chk("err_beats", beats, 3);
    pop_chk("err_rsp0", 32'hB0000000, 1'b0, 1'b0);
    pop_chk("err_rsp1", 32'hB0000001, 1'b0, 1'b1);
    pop_chk("err_rsp2", 32'hB0000002, 1'b0, 1'b0);

    // Unsolicited ACK while idle
    chk("un_perr_before", protocol_err, 1'b0);
    ACK_I = 1;
    tick();
    ACK_I = 0;
    tick();
    chk("un_perr", protocol_err, 1'b1);
    chk("un_rsp_valid", rsp_valid, 1'b0);
    chk("un_outstanding", dut.out_q, 4'd0);
    chk("un_cyc", CYC_O, 1'b0);

    // Async reset with three beats outstanding and a fourth stalled on the bus
    for (int c = 0; c < 4; c++) begin
      req_valid = 1; req_we = 0; req_adr = 32'h300 + 32'(c * 4);
      tick();
    end
    req_valid = 0; STALL_I = 1;
    chk("ar_outstanding", dut.out_q, 4'd3);
    chk("ar_stb", STB_O, 1'b1);
    #2 RST = 1;
    #1;
    chk("ar_cyc", CYC_O, 1'b0);
    chk("ar_stb_clr", STB_O, 1'b0);
    chk("ar_rsp_valid", rsp_valid, 1'b0);
    chk("ar_perr", protocol_err, 1'b0);
    STALL_I = 0;
    tick();
    RST = 0;
    repeat (3) tick();
    chk("ar_no_rsp", rsp_valid, 1'b0);
    chk("ar_cyc_idle", CYC_O, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wishbone_master_xactor.md
Name: wishbone_master_xactor

Overview:
Pipelined Wishbone B4 master transactor. It takes client requests on a valid/ready interface and issues them as pipelined STB beats within one CYC. It collects ACK/ERR terminations in order and returns them as responses on a second valid/ready interface. It is the bus-initiator counterpart of the slave transactor and drives the same 32-bit Wishbone fabric.

Parameters:
ADDR_WIDTH, 32, width of ADR_O and req_adr
DATA_WIDTH, 32, width of DAT_O/DAT_I and data paths; SEL width = DATA_WIDTH/8
MAX_OUTSTANDING, 8, maximum in-flight beats; also the response FIFO depth (power of 2, >=2)

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  reset, asynchronous, active-high
req_valid  in  1  client request present
req_ready  out  1  request accepted this cycle when req_valid && req_ready
req_we  in  1  1=write, 0=read
req_sel  in  DATA_WIDTH/8  byte selects
req_adr  in  ADDR_WIDTH  address
req_dat  in  DATA_WIDTH  write data
rsp_valid  out  1  response available (FIFO head)
rsp_ready  in  1  client consumes response
rsp_dat  out  DATA_WIDTH  read data (0 for writes)
rsp_we  out  1  direction of the completed beat
rsp_err  out  1  beat terminated by ERR_I
CYC_O  out  1  Wishbone cycle
STB_O  out  1  Wishbone strobe
WE_O  out  1  write enable
ADR_O  out  ADDR_WIDTH  address
SEL_O  out  DATA_WIDTH/8  byte selects
DAT_O  out  DATA_WIDTH  write data
STALL_I  in  1  slave stall
ACK_I  in  1  normal termination
ERR_I  in  1  error termination
DAT_I  in  DATA_WIDTH  read data
protocol_err  out  1  sticky: unsolicited ACK/ERR seen

Behaviour:
- Reset (async, immediate): CYC_O=STB_O=WE_O=0, ADR_O/SEL_O/DAT_O=0, outstanding=0, response FIFO empty (rsp_valid=0), protocol_err=0. Mid-cycle reset abandons in-flight beats; no responses are produced for them.
- Issue register: STB_O/WE_O/ADR_O/SEL_O/DAT_O are registered outputs. A request accepted in cycle N appears on the bus in cycle N+1.
- Beat issue: a beat is issued in a cycle with STB_O && !STALL_I. While STB_O && STALL_I, all bus outputs hold stable.
- req_ready = (!STB_O || !STALL_I) && credit_ok && dir_ok.
  - credit_ok: outstanding + fifo_count + STB_O < MAX_OUTSTANDING. This guarantees every ACK has a FIFO slot, because ACK cannot be backpressured.
  - dir_ok: either CYC_O=0, or req_we==WE_O. A direction change waits until CYC_O has dropped.
- No accept while the issue register advances: STB_O falls to 0 and holds the previous field values. SEL/DAT are not zeroed.
- outstanding counter, width clog2(MAX_OUTSTANDING+1):
  - increments on beat issue;
  - decrements on (ACK_I||ERR_I) while eligible;
  - both in the same cycle: unchanged.
- Eligible termination: outstanding>0, or a beat is issued in the same cycle. Only ACK from the current or an earlier beat is allowed.
- Ineligible ACK/ERR (including any while CYC_O=0): ignored, no counter underflow, protocol_err set until reset.
- ACK_I and ERR_I both high: treated as ERR.
- Response push: each eligible termination pushes {DAT_I if read else 0, WE, ERR_I} into the FIFO, in order. Response order equals issue order.
- FIFO pop: on rsp_valid && rsp_ready. Push and pop in the same cycle are allowed when full or empty per standard FIFO rules. Occupancy never exceeds MAX_OUTSTANDING.
- CYC_O:
  - rises with the first STB_O;
  - stays high while STB_O || outstanding>0;
  - falls the cycle after the last termination when no new request is loaded. A request accepted in that same cycle keeps CYC_O high (back-to-back).
- Response latency: ACK in cycle M gives rsp_valid in cycle M+1.
- Wishbone rules: STB_O never without CYC_O; WE_O constant within a cycle; writes carry SEL_O as given (client guarantees SEL!=0 for writes).

Test Plan:
- Single read: req adr=0x100, we=0 at N -> STB_O@N+1; slave ACK@N+2, DAT_I=0xDEADBEEF -> rsp_valid@N+3 with rsp_dat=0xDEADBEEF, rsp_we=0, rsp_err=0; CYC_O=0@N+3.
- Stall hold: write adr=0x4, sel=0xF, dat=0x12345678 with STALL_I=1 for 3 cycles -> bus fields stable for all 3 cycles, req_ready=0; outstanding=1 after STALL_I drops.
- Credit limit: 10 back-to-back reads, rsp_ready=0, slave ACKs each beat -> exactly 8 beats issued, req_ready=0 with 8 responses queued; popping 1 response reopens req_ready.
- Direction switch: write at N, read requested at N+1 -> read not accepted until CYC_O has been low for one cycle; WE_O never changes while CYC_O=1.
- Error and unsolicited ACK:
  - ERR_I on the 2nd of 3 reads -> responses err=0,1,0 in order.
  - ACK_I with CYC_O=0 -> protocol_err=1, outstanding stays 0, no response.
- Async reset mid-burst: assert RST with outstanding=3 -> CYC_O/STB_O=0 immediately, rsp_valid=0, no responses after deassert.
